// File: rtl/restoring_div_ctrl.sv
// Sequential 8-bit unsigned restoring divider: one trial subtraction per cycle for 8 cycles.
// Optional build macro DIV_ZERO_TRAP_EN short-circuits divide-by-zero straight to the result.
module restoring_div_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       dz
);

    // Handshake: start is taken only while busy=0 (operands captured on that edge);
    // busy stays high until the edge that raises done; done is a one-cycle result strobe.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic [2:0] cnt;
    logic [7:0] r_q, q_q, d_q;

    logic       c;
    logic       bin;
    logic       bout;
    logic       keep;
    logic [7:0] r_sh, q_sh, diff;

`ifdef DIV_ZERO_TRAP_EN
    logic       trap_hold;
`endif

    // Subtract-with-borrow datapath fed with the shifted partial remainder.
    always_comb begin
        c            = r_q[7];
        r_sh         = {r_q[6:0], q_q[7]};
        q_sh         = {q_q[6:0], 1'b0};
        bin          = 1'b0;
        {bout, diff} = {1'b0, r_sh} - {1'b0, d_q} - {8'd0, bin};
        keep         = c | ~bout;
    end

    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
`ifdef DIV_ZERO_TRAP_EN
                    state_nx = (divisor == 8'd0) ? FIN : RUN;
`else
                    state_nx = RUN;
`endif
                end
            end
            RUN: begin
                if (cnt == 3'd0) state_nx = FIN;
            end
            FIN: begin
`ifdef DIV_ZERO_TRAP_EN
                if (!trap_hold) state_nx = IDLE;
`else
                state_nx = IDLE;
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 3'd7;
            r_q       <= 8'd0;
            q_q       <= 8'd0;
            d_q       <= 8'd0;
            done      <= 1'b0;
            quotient  <= 8'd0;
            remainder <= 8'd0;
            dz        <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
            trap_hold <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        q_q <= dividend;
                        r_q <= 8'd0;
                        d_q <= divisor;
                        cnt <= 3'd7;
`ifdef DIV_ZERO_TRAP_EN
                        // Preload the natural restoring result; the extra FIN cycle keeps done at E2.
                        if (divisor == 8'd0) begin
                            q_q       <= 8'hFF;
                            r_q       <= dividend;
                            trap_hold <= 1'b1;
                        end
`endif
                    end
                end
                RUN: begin
                    r_q <= keep ? diff : r_sh;
                    q_q <= q_sh | {7'd0, keep};
                    cnt <= cnt - 3'd1;
                end
                FIN: begin
`ifdef DIV_ZERO_TRAP_EN
                    if (trap_hold) begin
                        trap_hold <= 1'b0;
                    end else begin
                        quotient  <= q_q;
                        remainder <= r_q;
                        dz        <= (d_q == 8'd0);
                        done      <= 1'b1;
                    end
`else
                    quotient  <= q_q;
                    remainder <= r_q;
                    dz        <= (d_q == 8'd0);
                    done      <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_div_ctrl.sv
// Directed bench for restoring_div_ctrl: vector table plus back-to-back, ignored-start and reset sequences.
module tb_restoring_div_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       dz;

    int checks;
    int failures;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
    } vec_t;

    vec_t vecs[10];

`ifdef DIV_ZERO_TRAP_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = 9;
`endif

    restoring_div_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .dz       (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Waits after an accepted start (sampled just after E0) until done; returns edge index or 0 on timeout.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        for (int k = 1; k <= 30 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (done) lat = k;
            else if (busy) busy_cnt++;
        end
    endtask

    task automatic do_op(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input logic ez);
        int lat, bc, exp_lat;
        exp_lat = (b == 8'd0) ? ZLAT : 9;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = $urandom_range(255);
        divisor  = $urandom_range(255);
        wait_done(lat, bc);
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " quotient"}, 32'(quotient), 32'(eq));
        chk({name, " remainder"}, 32'(remainder), 32'(er));
        chk({name, " dz"}, 32'(dz), 32'(ez));
        chk({name, " busy_cycles"}, 32'(bc), 32'(exp_lat));
        chk({name, " busy_at_done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk({name, " done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat, bc, seen;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;

        vecs[0] = '{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4,   z: 1'b0};
        vecs[1] = '{a: 8'd5,   b: 8'd3,   q: 8'd1,   r: 8'd2,   z: 1'b0};
        vecs[2] = '{a: 8'd8,   b: 8'd12,  q: 8'd0,   r: 8'd8,   z: 1'b0};
        vecs[3] = '{a: 8'h80,  b: 8'h00,  q: 8'hFF,  r: 8'h80,  z: 1'b1};
        vecs[4] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,   z: 1'b0};
        vecs[5] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,   z: 1'b0};
        vecs[6] = '{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0,   z: 1'b0};
        vecs[7] = '{a: 8'd254, b: 8'd128, q: 8'd1,   r: 8'd126, z: 1'b0};
        vecs[8] = '{a: 8'd13,  b: 8'd0,   q: 8'hFF,  r: 8'd13,  z: 1'b1};
        vecs[9] = '{a: 8'd99,  b: 8'd10,  q: 8'd9,   r: 8'd9,   z: 1'b0};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset quotient", 32'(quotient), 32'd0);
        chk("reset remainder", 32'(remainder), 32'd0);
        chk("reset dz", 32'(dz), 32'd0);

        for (int i = 0; i < 10; i++)
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z);

        // Back-to-back with start held high: 255/1 then 255/255.
        @(negedge clk);
        dividend = 8'd255; divisor = 8'd1; start = 1'b1;
        @(posedge clk); #1;
        divisor = 8'd255;
        wait_done(lat, bc);
        chk("b2b first latency", 32'(lat), 32'd9);
        chk("b2b first quotient", 32'(quotient), 32'd255);
        chk("b2b first remainder", 32'(remainder), 32'd0);
        lat = 0;
        for (int k = 1; k <= 30 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (done) lat = k;
        end
        start = 1'b0;
        chk("b2b spacing", 32'(lat), 32'd10);
        chk("b2b second quotient", 32'(quotient), 32'd1);
        chk("b2b second remainder", 32'(remainder), 32'd0);
        repeat (2) @(posedge clk);

        // Start pulsed at E3 while busy must be ignored.
        @(negedge clk);
        dividend = 8'd100; divisor = 8'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        dividend = 8'd50; divisor = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int k = 4; k <= 30 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (done) lat = k;
        end
        chk("ignored start latency", 32'(lat), 32'd9);
        chk("ignored start quotient", 32'(quotient), 32'd11);
        chk("ignored start remainder", 32'(remainder), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("ignored start no restart", 32'(busy), 32'd0);

        // Reset asserted at E4 of a 200/7 divide.
        @(negedge clk);
        dividend = 8'd200; divisor = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset done", 32'(done), 32'd0);
        chk("midreset quotient", 32'(quotient), 32'd0);
        chk("midreset remainder", 32'(remainder), 32'd0);
        chk("midreset dz", 32'(dz), 32'd0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("midreset no done", 32'(seen), 32'd0);
        do_op("after reset 15/10", 8'd15, 8'd10, 8'd1, 8'd5, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
